// File: rtl/uart_rx_param.sv
// Parametrised oversampling UART receiver with a valid/ready output register.
// Optional parity checking (extra PARITY state and parity_odd port) via UART_RX_PARITY_EN.
module uart_rx_param #(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16,
  parameter int STOP_BITS  = 1
) (
  input  logic                 clk_rx,
  input  logic                 reset,
  input  logic                 rx_input,
  input  logic                 baud_tick,
`ifdef UART_RX_PARITY_EN
  input  logic                 parity_odd,
`endif
  output logic [DATA_BITS-1:0] out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 frame_err,
  output logic                 overrun_err,
  output logic                 parity_err,
  output logic                 busy
);

  localparam int CNT_W = $clog2(OVERSAMPLE);
  localparam int BIT_W = 4;
  localparam logic [CNT_W-1:0] CNT_ZERO  = CNT_W'(0);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(OVERSAMPLE / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(OVERSAMPLE - 1);
  localparam logic [BIT_W-1:0] BIT_ZERO  = BIT_W'(0);
  localparam logic [BIT_W-1:0] BIT_ONE   = BIT_W'(1);
  localparam logic [BIT_W-1:0] DATA_LAST = BIT_W'(DATA_BITS - 1);
  localparam logic [BIT_W-1:0] STOP_LAST = BIT_W'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_DATA      = 3'd2,
    ST_PARITY    = 3'd3,
    ST_STOP      = 3'd4,
    ST_WAIT_HIGH = 3'd5
  } state_t;

  state_t                 state_r, state_next;
  logic [CNT_W-1:0]       tick_cnt_r, tick_next;
  logic [BIT_W-1:0]       bit_cnt_r, bit_next;
  logic [DATA_BITS-1:0]   shift_r, shift_next;
  logic [DATA_BITS-1:0]   out_data_r;
  logic                   rx_meta_r, rx_sync_r, rx_s;
  logic                   out_valid_r, frame_err_r, overrun_err_r, busy_r;
  logic                   done_s, frame_bad_s;

`ifdef UART_RX_PARITY_EN
  logic par_bad_r, par_bad_next, parity_err_r;

  // Expected parity bit: makes the total count of ones even, or odd when odd=1.
  function automatic logic calc_parity(input logic [DATA_BITS-1:0] data, input logic odd);
    calc_parity = (^data) ^ odd;
  endfunction
`endif

  assign rx_s = rx_sync_r;

  // Frame sequencing: every counter and transition advances on baud_tick only.
  always_comb begin
    state_next  = state_r;
    tick_next   = tick_cnt_r;
    bit_next    = bit_cnt_r;
    shift_next  = shift_r;
`ifdef UART_RX_PARITY_EN
    par_bad_next = par_bad_r;
`endif
    done_s      = 1'b0;
    frame_bad_s = 1'b0;
    if (baud_tick) begin
      case (state_r)
        ST_IDLE: begin
          if (!rx_s) begin
            state_next = ST_START;
            tick_next  = CNT_ZERO;
          end else begin
            state_next = ST_IDLE;
          end
        end
        ST_START: begin
          if (tick_cnt_r == HALF_LAST) begin
            tick_next  = CNT_ZERO;
            bit_next   = BIT_ZERO;
            state_next = rx_s ? ST_IDLE : ST_DATA;
          end else begin
            tick_next = tick_cnt_r + CNT_ONE;
          end
        end
        ST_DATA: begin
          if (tick_cnt_r == FULL_LAST) begin
            tick_next  = CNT_ZERO;
            // LSB arrives first, so right-shifting leaves it at bit 0 after the last sample
            shift_next = {rx_s, shift_r[DATA_BITS-1:1]};
            if (bit_cnt_r == DATA_LAST) begin
              bit_next = BIT_ZERO;
`ifdef UART_RX_PARITY_EN
              state_next = ST_PARITY;
`else
              state_next = ST_STOP;
`endif
            end else begin
              bit_next = bit_cnt_r + BIT_ONE;
            end
          end else begin
            tick_next = tick_cnt_r + CNT_ONE;
          end
        end
        ST_PARITY: begin
          if (tick_cnt_r == FULL_LAST) begin
            tick_next  = CNT_ZERO;
`ifdef UART_RX_PARITY_EN
            par_bad_next = (rx_s != calc_parity(shift_r, parity_odd));
`endif
            state_next = ST_STOP;
          end else begin
            tick_next = tick_cnt_r + CNT_ONE;
          end
        end
        ST_STOP: begin
          if (tick_cnt_r == FULL_LAST) begin
            tick_next = CNT_ZERO;
            if (!rx_s) begin
              frame_bad_s = 1'b1;
              bit_next    = BIT_ZERO;
              state_next  = ST_WAIT_HIGH;
            end else if (bit_cnt_r == STOP_LAST) begin
              done_s     = 1'b1;
              bit_next   = BIT_ZERO;
              state_next = ST_IDLE;
            end else begin
              bit_next = bit_cnt_r + BIT_ONE;
            end
          end else begin
            tick_next = tick_cnt_r + CNT_ONE;
          end
        end
        ST_WAIT_HIGH: begin
          if (rx_s) begin
            state_next = ST_IDLE;
          end else begin
            state_next = ST_WAIT_HIGH;
          end
        end
        default: begin
          state_next = ST_IDLE;
        end
      endcase
    end else begin
      state_next = state_r;
    end
  end

  // Synchroniser, FSM state and counters.
  always_ff @(posedge clk_rx) begin
    if (reset) begin
      rx_meta_r  <= 1'b1;
      rx_sync_r  <= 1'b1;
      state_r    <= ST_IDLE;
      tick_cnt_r <= CNT_ZERO;
      bit_cnt_r  <= BIT_ZERO;
      shift_r    <= {DATA_BITS{1'b0}};
      busy_r     <= 1'b0;
    end else begin
      rx_meta_r  <= rx_input;
      rx_sync_r  <= rx_meta_r;
      state_r    <= state_next;
      tick_cnt_r <= tick_next;
      bit_cnt_r  <= bit_next;
      shift_r    <= shift_next;
      busy_r     <= (state_next != ST_IDLE);
    end
  end

  // Output register, handshake and error pulses.
  always_ff @(posedge clk_rx) begin
    if (reset) begin
      out_data_r    <= {DATA_BITS{1'b0}};
      out_valid_r   <= 1'b0;
      frame_err_r   <= 1'b0;
      overrun_err_r <= 1'b0;
    end else begin
      frame_err_r   <= frame_bad_s;
      overrun_err_r <= 1'b0;
      if (done_s && (!out_valid_r || out_ready)) begin
        out_data_r  <= shift_r;
        out_valid_r <= 1'b1;
      end else if (done_s) begin
        overrun_err_r <= 1'b1;
      end else if (out_valid_r && out_ready) begin
        out_valid_r <= 1'b0;
      end
    end
  end

`ifdef UART_RX_PARITY_EN
  // Parity flag captured mid-frame; reported when the stop bits resolve.
  always_ff @(posedge clk_rx) begin
    if (reset) begin
      par_bad_r    <= 1'b0;
      parity_err_r <= 1'b0;
    end else begin
      par_bad_r    <= par_bad_next;
      parity_err_r <= (done_s | frame_bad_s) & par_bad_r;
    end
  end

  assign parity_err = parity_err_r;
`else
  assign parity_err = 1'b0;
`endif

  assign out_data    = out_data_r;
  assign out_valid   = out_valid_r;
  assign frame_err   = frame_err_r;
  assign overrun_err = overrun_err_r;
  assign busy        = busy_r;

endmodule

// File: tb/tb_uart_rx_param.sv
// Directed bench for uart_rx_param (defaults: 8 data bits, x16 oversampling, 1 stop bit).
// Delivered words are checked against a queue of expected words filled by the stimulus.
module tb_uart_rx_param;

  localparam int OS = 16;

  logic       clk_rx = 1'b0;
  logic       reset;
  logic       rx_input;
  logic       baud_tick;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic       frame_err;
  logic       overrun_err;
  logic       parity_err;
  logic       busy;
`ifdef UART_RX_PARITY_EN
  logic       parity_odd;
  logic       tx_par;
`endif

  int         n_cmp = 0;
  int         n_bad = 0;
  int         valid_cycles = 0;
  int         n_frame = 0;
  int         n_overrun = 0;
  int         n_parity = 0;
  logic [7:0] exp_q[$];

  uart_rx_param #(.DATA_BITS(8), .OVERSAMPLE(OS), .STOP_BITS(1)) dut (
    .clk_rx      (clk_rx),
    .reset       (reset),
    .rx_input    (rx_input),
    .baud_tick   (baud_tick),
`ifdef UART_RX_PARITY_EN
    .parity_odd  (parity_odd),
`endif
    .out_data    (out_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .frame_err   (frame_err),
    .overrun_err (overrun_err),
    .parity_err  (parity_err),
    .busy        (busy)
  );

  always #5 clk_rx = ~clk_rx;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    rx_input = 1'b1;
    repeat (n) begin
      @(posedge clk_rx);
      #1;
    end
  endtask

  // Drives start, data (LSB first), optional parity, one stop bit, then tail_low extra
  // low cycles. Returns early, without releasing the line, when abort_at cycles have elapsed.
  task automatic send_frame(input logic [7:0] d, input logic stop_v, input int tail_low,
                            input int abort_at);
    logic [11:0] bits;
    int          nb;
    int          cyc;
    bits = 12'hFFF;
    nb = 0;
    bits[nb] = 1'b0;
    nb++;
    for (int i = 0; i < 8; i++) begin
      bits[nb] = d[i];
      nb++;
    end
`ifdef UART_RX_PARITY_EN
    bits[nb] = tx_par;
    nb++;
`endif
    bits[nb] = stop_v;
    nb++;
    cyc = 0;
    for (int b = 0; b < nb; b++) begin
      for (int t = 0; t < OS; t++) begin
        if (cyc == abort_at) return;
        rx_input = bits[b];
        @(posedge clk_rx);
        #1;
        cyc++;
      end
    end
    for (int t = 0; t < tail_low; t++) begin
      rx_input = 1'b0;
      @(posedge clk_rx);
      #1;
    end
    rx_input = 1'b1;
  endtask

  // Output monitor: pulse counters and scoreboard check on every accepted word.
  always @(negedge clk_rx) begin
    if (!reset) begin
      if (out_valid) valid_cycles++;
      if (frame_err) n_frame++;
      if (overrun_err) n_overrun++;
      if (parity_err) n_parity++;
      if (out_valid && out_ready) begin
        check("word_expected", 32'(exp_q.size() > 0), 32'd1);
        if (exp_q.size() > 0) check("out_data", 32'(out_data), 32'(exp_q.pop_front()));
      end
    end
  end

  initial begin
    int v0, f0, o0;
    reset     = 1'b1;
    rx_input  = 1'b1;
    baud_tick = 1'b1;
    out_ready = 1'b1;
`ifdef UART_RX_PARITY_EN
    parity_odd = 1'b0;
    tx_par     = 1'b0;
`endif
    repeat (3) @(posedge clk_rx);
    #1;
    reset = 1'b0;
    @(negedge clk_rx);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_frame_err", 32'(frame_err), 32'd0);
    check("rst_overrun_err", 32'(overrun_err), 32'd0);
    check("rst_parity_err", 32'(parity_err), 32'd0);
    idle(4);

    // 1: plain frame
    v0 = valid_cycles; f0 = n_frame; o0 = n_overrun;
    exp_q.push_back(8'hA5);
    send_frame(8'hA5, 1'b1, 0, -1);
    @(negedge clk_rx);
    check("t1_busy_after_stop", 32'(busy), 32'd0);
    idle(20);
    check("t1_valid_one_cycle", 32'(valid_cycles - v0), 32'd1);
    check("t1_no_frame_err", 32'(n_frame - f0), 32'd0);
    check("t1_no_overrun", 32'(n_overrun - o0), 32'd0);

    // 2: start glitch
    v0 = valid_cycles;
    rx_input = 1'b0;
    repeat (3) @(posedge clk_rx);
    @(negedge clk_rx);
    check("t2_busy_on_glitch", 32'(busy), 32'd1);
    @(posedge clk_rx);
    #1;
    rx_input = 1'b1;
    idle(30);
    check("t2_busy_cleared", 32'(busy), 32'd0);
    check("t2_no_word", 32'(valid_cycles - v0), 32'd0);
    exp_q.push_back(8'h3C);
    send_frame(8'h3C, 1'b1, 0, -1);
    idle(20);

    // 3: framing error followed by a held-low break
    v0 = valid_cycles; f0 = n_frame;
    send_frame(8'h55, 1'b0, 40, -1);
    idle(40);
    check("t3_frame_err_once", 32'(n_frame - f0), 32'd1);
    check("t3_no_word", 32'(valid_cycles - v0), 32'd0);
    check("t3_busy_cleared", 32'(busy), 32'd0);
    exp_q.push_back(8'h0F);
    send_frame(8'h0F, 1'b1, 0, -1);
    idle(20);

    // 4: overrun while the consumer stalls
    o0 = n_overrun;
    out_ready = 1'b0;
    exp_q.push_back(8'h11);
    send_frame(8'h11, 1'b1, 0, -1);
    idle(10);
    send_frame(8'h22, 1'b1, 0, -1);
    idle(20);
    @(negedge clk_rx);
    check("t4_overrun_once", 32'(n_overrun - o0), 32'd1);
    check("t4_valid_held", 32'(out_valid), 32'd1);
    check("t4_old_word_kept", 32'(out_data), 32'h11);
    @(posedge clk_rx);
    #1;
    out_ready = 1'b1;
    @(negedge clk_rx);
    @(negedge clk_rx);
    check("t4_valid_cleared", 32'(out_valid), 32'd0);
    idle(10);

    // 5: reset mid-frame drops a pending word and the partial frame
    out_ready = 1'b0;
    exp_q.push_back(8'h5A);
    send_frame(8'h5A, 1'b1, 0, -1);
    idle(20);
    @(negedge clk_rx);
    check("t5_pending_word", 32'(out_data), 32'h5A);
    send_frame(8'hFF, 1'b1, 0, OS + 4 * OS + OS / 2);
    @(negedge clk_rx);
    check("t5_busy_in_data", 32'(busy), 32'd1);
    reset = 1'b1;
    @(posedge clk_rx);
    @(negedge clk_rx);
    check("t5_rst_out_valid", 32'(out_valid), 32'd0);
    check("t5_rst_out_data", 32'(out_data), 32'd0);
    check("t5_rst_busy", 32'(busy), 32'd0);
    reset = 1'b0;
    void'(exp_q.pop_front());
    out_ready = 1'b1;
    idle(20);
    exp_q.push_back(8'h81);
    send_frame(8'h81, 1'b1, 0, -1);
    idle(20);

`ifdef UART_RX_PARITY_EN
    // 6: even parity, 0x07 needs parity bit 1
    o0 = n_parity;
    parity_odd = 1'b0;
    tx_par = 1'b0;
    exp_q.push_back(8'h07);
    send_frame(8'h07, 1'b1, 0, -1);
    idle(20);
    check("t6_parity_err", 32'(n_parity - o0), 32'd1);
    o0 = n_parity;
    tx_par = 1'b1;
    exp_q.push_back(8'h07);
    send_frame(8'h07, 1'b1, 0, -1);
    idle(20);
    check("t6_parity_ok", 32'(n_parity - o0), 32'd0);
`endif

    check("all_words_delivered", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
